// File: rtl/decoder_4x16_hold_pkg.sv
// Shared types and constants for the 4x16 decoder and the matching 16x4 encoder.
package decoder_4x16_hold_pkg;

    localparam int CODE_W = 4;
    localparam int OUT_W  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Width of a counter that must hold values 0..hold.
    function automatic int cnt_width(input int hold);
        return $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/decoder_4x16_hold_core.sv
// Combinational one-hot decode of a 4-bit code; all zeros when disabled.
module decoder_4x16_core
    import decoder_4x16_hold_pkg::*;
(
    input  logic              en,
    input  logic [CODE_W-1:0] i,
    output logic [OUT_W-1:0]  y
);

    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
            assign y[gi] = en && (i == CODE_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/decoder_4x16_hold.sv
// Decoder that holds each accepted one-hot result for HOLD_CYCLES cycles,
// accepting the next request in the final hold cycle so streams run gap-free.
module decoder_4x16_hold
    import decoder_4x16_hold_pkg::*;
#(
    parameter int HOLD_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [CODE_W-1:0] i,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  y,
    output logic              out_valid
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [OUT_W-1:0]  y_q;
    logic [OUT_W-1:0]  y_d;
    logic              out_valid_q;
    logic              accept;

    decoder_4x16_core u_core (
        .en (en),
        .i  (i),
        .y  (y_d)
    );

    // cnt_q is zero in IDLE, but the state term keeps the intent readable.
    assign in_ready  = (state_q == IDLE) || (cnt_q == '0);
    assign accept    = in_valid && in_ready;
    assign y         = y_q;
    assign out_valid = out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= HOLD;
                        cnt_q       <= CNT_LOAD;
                        y_q         <= y_d;
                        out_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (accept) begin
                        cnt_q       <= CNT_LOAD;
                        y_q         <= y_d;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q     <= IDLE;
                        y_q         <= '0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    y_q         <= '0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_4x16_hold.sv
// Bench for decoder_4x16_hold: two instances (hold 3 and hold 1) checked every
// cycle against a remaining-cycles model, plus literal directed expectations.
module tb_decoder_4x16_hold;

    logic        clk;
    logic        rst_n;

    logic        v3, en3, rdy3, ov3;
    logic [3:0]  i3;
    logic [15:0] y3;

    logic        v1, en1, rdy1, ov1;
    logic [3:0]  i1;
    logic [15:0] y1;

    int total = 0;
    int bad   = 0;

    decoder_4x16_hold #(.HOLD_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .i(i3), .in_valid(v3),
        .in_ready(rdy3), .y(y3), .out_valid(ov3)
    );

    decoder_4x16_hold #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .i(i1), .in_valid(v1),
        .in_ready(rdy1), .y(y1), .out_valid(ov1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: cycles of out_valid still owed (including the current one) and the held value.
    int          rem3 = 0;
    logic [15:0] val3 = '0;
    int          rem1 = 0;
    logic [15:0] val1 = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem3 = 0; val3 = '0;
            rem1 = 0; val1 = '0;
        end else begin
            if (v3 && rem3 <= 1) begin
                rem3 = 3;
                val3 = en3 ? (16'd1 << i3) : 16'd0;
            end else if (rem3 > 0) begin
                rem3 = rem3 - 1;
                if (rem3 == 0) val3 = '0;
            end
            if (v1 && rem1 <= 1) begin
                rem1 = 1;
                val1 = en1 ? (16'd1 << i1) : 16'd0;
            end else if (rem1 > 0) begin
                rem1 = rem1 - 1;
                if (rem1 == 0) val1 = '0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("h3_y",     32'(y3),   32'(val3));
            chk("h3_valid", 32'(ov3),  32'(rem3 > 0));
            chk("h3_ready", 32'(rdy3), 32'(rem3 <= 1));
            chk("h1_y",     32'(y1),   32'(val1));
            chk("h1_valid", 32'(ov1),  32'(rem1 > 0));
            chk("h1_ready", 32'(rdy1), 32'(rem1 <= 1));
            chk("h3_onehot", 32'($countones(y3) <= 1), 32'd1);
        end
    end

    task automatic wait_rdy3();
        int n = 0;
        @(negedge clk);
        while (!rdy3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy3) begin
            total++;
            bad++;
            $display("FAIL wait_ready: got 0 expected 1 within 20 cycles at %0t", $time);
        end
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        v3 = 0; en3 = 0; i3 = 0;
        v1 = 0; en1 = 0; i1 = 0;
        #1;
        chk("rst_y",     32'(y3),   32'h0);
        chk("rst_valid", 32'(ov3),  32'h0);
        chk("rst_ready", 32'(rdy3), 32'h1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request, code 5.
        @(posedge clk); #1;
        v3 = 1; i3 = 4'h5; en3 = 1;
        @(posedge clk); #1;
        v3 = 0;
        chk("single_y", 32'(y3), 32'h0020);
        @(negedge clk); chk("single_rdy0", 32'(rdy3), 32'h0);
        @(negedge clk); chk("single_rdy1", 32'(rdy3), 32'h0);
        @(negedge clk); chk("single_rdy2", 32'(rdy3), 32'h1);
        chk("single_ov2", 32'(ov3), 32'h1);
        @(negedge clk); chk("single_end_y", 32'(y3), 32'h0);
        chk("single_end_ov", 32'(ov3), 32'h0);

        // Back-to-back sweep 1..9.
        @(posedge clk); #1;
        v3 = 1; en3 = 1;
        for (int c = 1; c <= 9; c++) begin
            i3 = 4'(c);
            wait_rdy3();
            @(posedge clk); #1;
            if (c == 1) chk("sweep_first_y", 32'(y3), 32'h0002);
            if (c == 9) chk("sweep_last_y", 32'(y3), 32'h0200);
        end
        v3 = 0;
        repeat (4) @(posedge clk);
        #1;

        // Disabled decode.
        v3 = 1; en3 = 0; i3 = 4'hA;
        @(posedge clk); #1;
        v3 = 0;
        chk("dis_y",  32'(y3),  32'h0);
        chk("dis_ov", 32'(ov3), 32'h1);
        repeat (4) @(posedge clk);
        #1;

        // Stall immunity: inputs churn while in_ready is low.
        v3 = 1; en3 = 1; i3 = 4'h3;
        @(posedge clk); #1;
        guard = 0;
        while (!rdy3 && guard < 10) begin
            chk("stall_y", 32'(y3), 32'h0008);
            i3 = 4'($urandom_range(0, 15));
            en3 = ~en3;
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        v3 = 0;
        repeat (4) @(posedge clk);
        #1;

        // HOLD_CYCLES=1 boundary codes.
        v1 = 1; en1 = 1; i1 = 4'h0;
        @(posedge clk); #1;
        chk("b1_y0",   32'(y1),   32'h0001);
        chk("b1_rdy0", 32'(rdy1), 32'h1);
        i1 = 4'hF;
        @(posedge clk); #1;
        chk("b1_yF",   32'(y1),   32'h8000);
        chk("b1_rdyF", 32'(rdy1), 32'h1);
        v1 = 0;
        @(posedge clk); #1;
        chk("b1_end_y",  32'(y1),  32'h0);
        chk("b1_end_ov", 32'(ov1), 32'h0);

        // Random traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            v3 = 1'($urandom_range(0, 1)); en3 = 1'($urandom_range(0, 3) != 0);
            i3 = 4'($urandom_range(0, 15));
            v1 = 1'($urandom_range(0, 1)); en1 = 1'($urandom_range(0, 3) != 0);
            i1 = 4'($urandom_range(0, 15));
        end
        v3 = 0; v1 = 0;
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a hold of 16'h0010.
        v3 = 1; en3 = 1; i3 = 4'h4;
        @(posedge clk); #1;
        v3 = 0;
        chk("arst_pre_y", 32'(y3), 32'h0010);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_y",     32'(y3),   32'h0);
        chk("arst_ov",    32'(ov3),  32'h0);
        chk("arst_ready", 32'(rdy3), 32'h1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_after_y",  32'(y3),  32'h0);
        chk("arst_after_ov", 32'(ov3), 32'h0);
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
